// File: rtl/vga_ctrl.sv
// VGA timing generator: free-running line/frame counters, sync pulses, a pixel request
// window one clock ahead of the display window, and a frame-start pulse with frame counter.
module vga_ctrl #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 40,
  parameter int unsigned H_LEFT   = 8,
  parameter int unsigned H_VALID  = 640,
  parameter int unsigned H_RIGHT  = 8,
  parameter int unsigned H_FRONT  = 8,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 25,
  parameter int unsigned V_TOP    = 8,
  parameter int unsigned V_VALID  = 480,
  parameter int unsigned V_BOTTOM = 8,
  parameter int unsigned V_FRONT  = 2,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned HS = H_SYNC + H_BACK + H_LEFT;
  localparam int unsigned VS = V_SYNC + V_BACK + V_TOP;

  localparam logic [9:0] HLast     = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast     = 10'(V_TOTAL - 1);
  localparam logic [9:0] HSyncEnd  = 10'(H_SYNC);
  localparam logic [9:0] VSyncEnd  = 10'(V_SYNC);
  localparam logic [9:0] HValStart = 10'(HS);
  localparam logic [9:0] HValEnd   = 10'(HS + H_VALID);
  localparam logic [9:0] HReqStart = 10'(HS - 1);
  localparam logic [9:0] HReqEnd   = 10'(HS + H_VALID - 1);
  localparam logic [9:0] VValStart = 10'(VS);
  localparam logic [9:0] VValEnd   = 10'(VS + V_VALID);
  localparam logic [9:0] PixNone   = 10'h3FF;

  // Totals are free parameters; catch an inconsistent override at elaboration.
  if (H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT != H_TOTAL) begin : g_h_chk
    $error("vga_ctrl: horizontal terms do not sum to H_TOTAL");
  end
  if (V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT != V_TOTAL) begin : g_v_chk
    $error("vga_ctrl: vertical terms do not sum to V_TOTAL");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 2 || V_TOTAL < 1) begin : g_w_chk
    $error("vga_ctrl: totals must fit the 10-bit counters");
  end

  logic [9:0] cnt_h_q, cnt_h_d;
  logic [9:0] cnt_v_q, cnt_v_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       h_end, v_end;
  logic       rgb_valid, pix_req;

  always_comb begin
    h_end         = (cnt_h_q == HLast);
    v_end         = (cnt_v_q == VLast);
    cnt_h_d       = h_end ? 10'd0 : cnt_h_q + 10'd1;
    cnt_v_d       = cnt_v_q;
    if (h_end) begin
      cnt_v_d = v_end ? 10'd0 : cnt_v_q + 10'd1;
    end
    // Registered so the pulse coincides with the (0,0) position after a full-frame wrap.
    frame_start_d = h_end & v_end;
    frame_cnt_d   = frame_start_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h_q       <= 10'd0;
      cnt_v_q       <= 10'd0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      cnt_h_q       <= cnt_h_d;
      cnt_v_q       <= cnt_v_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  always_comb begin
    hsync     = (cnt_h_q < HSyncEnd);
    vsync     = (cnt_v_q < VSyncEnd);
    rgb_valid = (cnt_h_q >= HValStart) && (cnt_h_q < HValEnd) &&
                (cnt_v_q >= VValStart) && (cnt_v_q < VValEnd);
    // Request leads display by one clock to cover the registered picture stage.
    pix_req   = (cnt_h_q >= HReqStart) && (cnt_h_q < HReqEnd) &&
                (cnt_v_q >= VValStart) && (cnt_v_q < VValEnd);
    pix_x     = pix_req ? cnt_h_q - HReqStart : PixNone;
    pix_y     = pix_req ? cnt_v_q - VValStart : PixNone;
    rgb       = rgb_valid ? pix_data : 16'h0000;
  end

  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_ctrl.sv
// Scoreboard bench for vga_ctrl on a shrunken raster (18 x 10 clocks, 8 x 4 active).
module tb_vga_ctrl;

  logic        vga_clk;
  logic        sys_rst_n;
  logic [15:0] pix_data;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        hsync;
  logic        vsync;
  logic [15:0] rgb;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  vga_ctrl #(
    .H_SYNC  (4),
    .H_BACK  (2),
    .H_LEFT  (1),
    .H_VALID (8),
    .H_RIGHT (1),
    .H_FRONT (2),
    .V_SYNC  (2),
    .V_BACK  (1),
    .V_TOP   (1),
    .V_VALID (4),
    .V_BOTTOM(1),
    .V_FRONT (1),
    .H_TOTAL (18),
    .V_TOTAL (10)
  ) dut (
    .vga_clk    (vga_clk),
    .sys_rst_n  (sys_rst_n),
    .pix_data   (pix_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb        (rgb),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt)
  );

  typedef enum {FHs, FVs, FPx, FPy, FRgb, FFs, FFc, FFfcnt} field_e;
  typedef struct {
    int unsigned cyc;
    field_e      fld;
    logic [15:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned cyc;
  int unsigned ffff_cnt;
  int unsigned n_pass;
  int unsigned n_total;
  logic        blank;

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  // Picture stage: registered function of the request coordinates.
  always @(posedge vga_clk) begin
    pix_data <= blank ? 16'hFFFF : {1'b1, pix_y[4:0], pix_x};
  end

  // Clocks since the latest reset release == raster position index.
  always @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cyc <= 0;
    else            cyc <= cyc + 1;
  end

  function automatic string fname(field_e f);
    case (f)
      FHs:     return "hsync";
      FVs:     return "vsync";
      FPx:     return "pix_x";
      FPy:     return "pix_y";
      FRgb:    return "rgb";
      FFs:     return "frame_start";
      FFc:     return "frame_cnt";
      default: return "ffff_count";
    endcase
  endfunction

  function automatic logic [15:0] get_act(field_e f);
    case (f)
      FHs:     return {15'd0, hsync};
      FVs:     return {15'd0, vsync};
      FPx:     return {6'd0, pix_x};
      FPy:     return {6'd0, pix_y};
      FRgb:    return rgb;
      FFs:     return {15'd0, frame_start};
      FFc:     return {8'd0, frame_cnt};
      default: return 16'(ffff_cnt);
    endcase
  endfunction

  task automatic check(input string name, input int unsigned at, input logic [15:0] act,
                       input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h, expected %h", name, at, act, exp);
  endtask

  task automatic push(input int unsigned at, input field_e f, input logic [15:0] v);
    exp_t x;
    x.cyc = at;
    x.fld = f;
    x.exp = v;
    sb.push_back(x);
  endtask

  // Monitor: pop every expectation due at the current raster position.
  always @(negedge vga_clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        n_total++;
        $display("FAIL %s @cyc %0d: missed, now at cyc %0d", fname(e.fld), e.cyc, cyc);
      end else begin
        check(fname(e.fld), e.cyc, get_act(e.fld), e.exp);
      end
    end
    if (cyc >= 360 && cyc < 540 && rgb == 16'hFFFF) ffff_cnt++;
  end

  initial begin
    n_pass    = 0;
    n_total   = 0;
    ffff_cnt  = 0;
    blank     = 1'b0;
    sys_rst_n = 1'b0;

    // In reset.
    push(0, FHs, 16'h1);    push(0, FVs, 16'h1);  push(0, FPx, 16'h3FF);
    push(0, FPy, 16'h3FF);  push(0, FRgb, 16'h0); push(0, FFs, 16'h0);
    push(0, FFc, 16'h0);
    // First frames: syncs, request/display alignment, wrap.
    push(1,   FFs, 16'h0);     push(3,   FHs, 16'h1);     push(4,   FHs, 16'h0);
    push(35,  FVs, 16'h1);     push(36,  FVs, 16'h0);     push(60,  FPx, 16'h3FF);
    push(77,  FPx, 16'h3FF);   push(78,  FPx, 16'h0);     push(78,  FPy, 16'h0);
    push(78,  FRgb, 16'h0);    push(79,  FRgb, 16'h8000); push(85,  FPx, 16'h7);
    push(86,  FPx, 16'h3FF);   push(86,  FRgb, 16'h8007); push(87,  FRgb, 16'h0);
    push(96,  FPy, 16'h1);     push(97,  FRgb, 16'h8400); push(132, FPy, 16'h3);
    push(140, FRgb, 16'h8C07); push(150, FPy, 16'h3FF);   push(179, FFs, 16'h0);
    push(179, FFc, 16'h0);     push(180, FFs, 16'h1);     push(180, FFc, 16'h1);
    push(181, FFs, 16'h0);     push(360, FFs, 16'h1);     push(360, FFc, 16'h2);
    // Third frame with pix_data stuck at FFFF.
    push(438, FRgb, 16'h0);    push(439, FRgb, 16'hFFFF); push(500, FRgb, 16'hFFFF);
    push(501, FRgb, 16'h0);    push(511, FRgb, 16'h0);    push(540, FFfcnt, 16'd32);
    push(540, FFc, 16'h3);     push(639, FFc, 16'h3);

    repeat (3) @(negedge vga_clk);
    #2 sys_rst_n = 1'b1;

    for (int i = 0; i < 400 && cyc < 300; i++) @(negedge vga_clk);
    if (cyc < 300) begin
      n_total++;
      $display("FAIL wait_300: got cyc %0d, expected 300", cyc);
    end
    blank = 1'b1;

    for (int i = 0; i < 500 && cyc != 640; i++) @(negedge vga_clk);
    if (cyc != 640) begin
      n_total++;
      $display("FAIL wait_640: got cyc %0d, expected 640", cyc);
    end

    // Mid-frame reset (line 5, column 10): must clear without a clock edge.
    #2 sys_rst_n = 1'b0;
    #1;
    check("async_frame_cnt",   640, {8'd0, frame_cnt}, 16'h0);
    check("async_frame_start", 640, {15'd0, frame_start}, 16'h0);
    check("async_hsync",       640, {15'd0, hsync}, 16'h1);
    check("async_vsync",       640, {15'd0, vsync}, 16'h1);
    check("async_pix_x",       640, {6'd0, pix_x}, 16'h3FF);
    check("async_pix_y",       640, {6'd0, pix_y}, 16'h3FF);
    check("async_rgb",         640, rgb, 16'h0);

    repeat (2) @(negedge vga_clk);
    push(1,     FFs, 16'h0);  push(179,   FFs, 16'h0);  push(179,   FFc, 16'h0);
    push(180,   FFs, 16'h1);  push(180,   FFc, 16'h1);  push(181,   FFs, 16'h0);
    push(360,   FFc, 16'h2);  push(45900, FFc, 16'hFF); push(46080, FFs, 16'h1);
    push(46080, FFc, 16'h0);  push(46081, FFs, 16'h0);
    #2 sys_rst_n = 1'b1;

    for (int i = 0; i < 47000 && sb.size() != 0; i++) @(negedge vga_clk);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end

    @(negedge vga_clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
